// File: rtl/brightness_pkg.sv
// Shared types and constants for the brightness key front-end.
package brightness_pkg;

   localparam int LEVEL_W = 4;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY    = 25000000;
   localparam int DEF_REPEAT_RATE     = 5000000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRESS  = 2'd1,
      ST_REPEAT = 2'd2,
      ST_CHORD  = 2'd3
   } key_state_e;

   typedef enum logic {
      KEY_UP = 1'b0,
      KEY_DN = 1'b1
   } key_sel_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/brightness_keys_if.sv
// Link between the board keys, the key front-end and the brightness stage.
interface brightness_keys_if;
   import brightness_pkg::*;

   // key_*_n are raw asynchronous levels (low = pressed). inc/dec/lvl_rst are
   // single-cycle registered pulses with no back-pressure: the consumer must
   // act on every cycle they are high. held and state are observation levels.
   logic       key_up_n;
   logic       key_dn_n;
   logic       inc;
   logic       dec;
   logic       lvl_rst;
   logic       held;
   key_state_e state;

   modport master (
      input  key_up_n, key_dn_n,
      output inc, dec, lvl_rst, held, state
   );

   modport slave (
      output key_up_n, key_dn_n,
      input  inc, dec, lvl_rst, held, state
   );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stable-state debounce counter for one
// active-low key; reports the accepted level as active-high pressed_o.
module key_debounce
   import brightness_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n_i,
   output logic pressed_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= key_n_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // The DEBOUNCE_CYCLES-th consecutive disagreeing sample flips the state
   // in the same edge, so the counter never has to hold the full count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign pressed_o = ~stable_q;

endmodule

// File: rtl/brightness_keys.sv
// Key front-end: debounces both keys and turns them into inc/dec pulses with
// auto-repeat, plus a level-reset pulse when both keys are pressed together.
module brightness_keys
   import brightness_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic              clk,
   input  logic              rst_n,
   brightness_keys_if.master bus
);

   localparam int CNT_W = $clog2(max2(REPEAT_DELAY, REPEAT_RATE)) + 1;
   localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);

   logic up_p;
   logic dn_p;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_i   (bus.key_up_n),
      .pressed_o (up_p)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_i   (bus.key_dn_n),
      .pressed_o (dn_p)
   );

   key_state_e       state_q;
   key_state_e       state_d;
   key_sel_e         active_q;
   key_sel_e         active_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             up_prev_q;
   logic             dn_prev_q;
   logic             inc_q;
   logic             inc_d;
   logic             dec_q;
   logic             dec_d;
   logic             lvl_rst_q;
   logic             lvl_rst_d;

   logic             up_rise;
   logic             dn_rise;
   logic             act_p;
   logic             oth_p;

   assign up_rise = up_p & ~up_prev_q;
   assign dn_rise = dn_p & ~dn_prev_q;
   assign act_p   = (active_q == KEY_UP) ? up_p : dn_p;
   assign oth_p   = (active_q == KEY_UP) ? dn_p : up_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         active_q  <= KEY_UP;
         cnt_q     <= '0;
         up_prev_q <= 1'b0;
         dn_prev_q <= 1'b0;
         inc_q     <= 1'b0;
         dec_q     <= 1'b0;
         lvl_rst_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         cnt_q     <= cnt_d;
         up_prev_q <= up_p;
         dn_prev_q <= dn_p;
         inc_q     <= inc_d;
         dec_q     <= dec_d;
         lvl_rst_q <= lvl_rst_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      cnt_d     = cnt_q;
      inc_d     = 1'b0;
      dec_d     = 1'b0;
      lvl_rst_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (up_rise || dn_rise) begin
               if (up_p && dn_p) begin
                  state_d   = ST_CHORD;
                  lvl_rst_d = 1'b1;
               end else begin
                  state_d  = ST_PRESS;
                  active_d = up_rise ? KEY_UP : KEY_DN;
                  cnt_d    = DELAY_LD;
                  inc_d    = up_rise;
                  dec_d    = ~up_rise;
               end
            end
         end
         ST_PRESS, ST_REPEAT: begin
            // Release beats a repeat pulse falling due on the same edge.
            if (!act_p) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (oth_p) begin
               state_d   = ST_CHORD;
               cnt_d     = '0;
               lvl_rst_d = 1'b1;
            end else if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_REPEAT;
               cnt_d   = RATE_LD;
               inc_d   = (active_q == KEY_UP);
               dec_d   = (active_q == KEY_DN);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_CHORD: begin
            if (!up_p && !dn_p) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.inc     = inc_q;
   assign bus.dec     = dec_q;
   assign bus.lvl_rst = lvl_rst_q;
   assign bus.held    = (state_q == ST_PRESS) || (state_q == ST_REPEAT);
   assign bus.state   = state_q;

endmodule

// File: doc/brightness_keys.md
# brightness_keys

Key front-end for the brightness stage. Takes the two raw, active-low DE1-SoC push-buttons and drives the brightness stage's `inc`/`dec` level controls with clean single-cycle pulses, with auto-repeat while a key is held. Also emits a level-reset pulse when both keys are pressed together. Sits between the board keys and the brightness stage, in the `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples needed to accept a key change (≥1).
- `REPEAT_DELAY`, default 25000000: cycles from the first pulse to the first auto-repeat pulse (≥1).
- `REPEAT_RATE`, default 5000000: cycles between later auto-repeat pulses (≥1).
- `clk` in 1: pixel/system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_up_n` in 1: raw "brighter" button, low = pressed, asynchronous.
- `key_dn_n` in 1: raw "dimmer" button, low = pressed, asynchronous.
- `inc` out 1: one-cycle pulse meaning increase level by one.
- `dec` out 1: one-cycle pulse meaning decrease level by one.
- `lvl_rst` out 1: one-cycle pulse meaning return level to default.
- `held` out 1: high while the FSM is in PRESS or REPEAT.

## Operation
- Synchronizer: each key passes through a 2-FF synchronizer. Both flops reset to 1 (released).
- Debounce, per key:
  - Stable state resets to released.
  - A counter runs while the synchronized value differs from the stable state. It clears when the values agree.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable state takes the synchronized value and the counter clears.
- FSM states: IDLE, PRESS, REPEAT, CHORD. It acts only on debounced states.
- IDLE:
  - Exactly one key newly pressed → go to PRESS and pulse `inc` (up key) or `dec` (down key). Load the repeat counter with `REPEAT_DELAY`.
  - Both keys become pressed in the same cycle → go to CHORD and pulse `lvl_rst`.
- PRESS:
  - Counter decrements each cycle.
  - When it reaches 0: pulse the same output, go to REPEAT, load `REPEAT_RATE`.
- REPEAT:
  - Counter decrements each cycle.
  - At 0: pulse the same output and reload `REPEAT_RATE`.
- PRESS or REPEAT, exits:
  - Active key released → IDLE, no pulse.
  - Other key becomes pressed (debounced) → CHORD, pulse `lvl_rst`. No `inc`/`dec` in that cycle.
- CHORD:
  - No pulses.
  - Stays in CHORD until both keys are released, then goes to IDLE.
  - Releasing one key and re-pressing it while in CHORD does nothing.
- Output rules:
  - `inc`, `dec` and `lvl_rst` are registered and mutually exclusive; at most one is high in any cycle.
  - `inc` and `dec` are never held high for two consecutive cycles.
- No saturation logic: the brightness stage clamps the level at 0 and 15. Pulses continue at either limit.
- Counters are sized `$clog2(max param)+1`. They never wrap; reloads happen only at 0.

## Timing
- Reset values: all outputs 0; FSM in IDLE; all counters 0; synchronizers and stable states released.
- Reset asserted mid-operation (including mid-repeat) clears state immediately and asynchronously. A key still held after reset release is treated as a new press: debounce, then one pulse.
- Press latency: raw key first sampled low at edge k and held low → `inc`/`dec` high for the single cycle following edge k+2+`DEBOUNCE_CYCLES`.
- Repeat timing: the first repeat pulse comes exactly `REPEAT_DELAY` cycles after the initial pulse. Later pulses are spaced exactly `REPEAT_RATE` cycles apart.
- Release latency: the debounced release takes effect `DEBOUNCE_CYCLES`+2 edges after the raw key goes high. A repeat pulse due before that point is still emitted.
- Bounce: any raw glitch shorter than `DEBOUNCE_CYCLES` cycles produces no state change and no pulse.

## Structure
- Shared package `brightness_pkg`:
  - FSM state enum.
  - `LEVEL_W = 4`.
  - Default parameter constants.
- Sub-module `key_debounce`: synchronizer plus debounce counter. Instantiated twice.
- FSM and repeat counter live in the top module.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_RATE=8`.
- Bounce: `key_up_n` toggles low/high every 2 cycles for 20 cycles, then stays high → no `inc`, `dec` or `lvl_rst` ever.
- Clean press: `key_up_n` low at edge 10, released after 15 cycles → exactly one `inc`, in the cycle after edge 16; `held` goes high, then low after release.
- Auto-repeat: `key_dn_n` held low for 60 cycles → `dec` at t0, t0+20, t0+28, t0+36, t0+44, t0+52 (t0 = first pulse); nothing after release.
- Chord: `key_up_n` held, then `key_dn_n` pressed 10 cycles later → one `inc`, then one `lvl_rst`; no pulses until both are released; a fresh up press afterwards gives `inc` again.
- Simultaneous press: both keys go low at the same edge → single `lvl_rst`, no `inc`/`dec`.
- Reset mid-repeat: `rst_n` pulsed low during REPEAT while the key stays held → outputs 0 immediately; one `inc` arrives 4+2 cycles after reset release, then the delay/rate sequence restarts.
